wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Byte-serial multi-precision adder front end for the 8-bit prefix adder. It accepts two NBYTES-wide operands one byte pair per beat, least-significant byte first. Each byte pair goes to the external 8-bit adder with the carry from the previous beat. The block registers each sum byte into a one-entry output stage with valid/ready handshake, and assembles the full-width result word with carry-out and signed-overflow flags. It sits directly upstream of the prefix adder, which it drives, and directly downstream of it, since it captures the adder's sum and carry.

## Interface
Parameters:
- NBYTES, 4: bytes per operand; legal range 2..8; total width W = 8*NBYTES.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous clear of the operation in progress; ignored while rst is high.
- in_valid  in  1  a_byte/b_byte/cin valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_byte  in  8  operand A byte, LSB-first.
- b_byte  in  8  operand B byte, LSB-first.
- cin  in  1  carry-in; sampled only on beat 0.
- add_a  out  8  to prefix adder operand A; equals a_byte.
- add_b  out  8  to prefix adder operand B; equals b_byte.
- add_cin  out  1  to prefix adder carry-in.
- add_sum  in  8  from prefix adder; combinational result of add_a+add_b+add_cin.
- add_cout  in  1  from prefix adder carry-out.
- out_valid  out  1  sum_byte valid.
- out_ready  in  1  downstream accepts sum_byte.
- sum_byte  out  8  registered sum byte.
- out_last  out  1  sum_byte is the most-significant byte.
- word_valid  out  1  one-cycle pulse: sum_word/cout/ovf updated.
- sum_word  out  W  assembled full result.
- cout  out  1  final carry-out of the W-bit add.
- ovf  out  1  signed overflow of the W-bit add.

## Operation
- Beat counter `beat` runs 0..NBYTES-1; a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output stage has one entry and passes straight through, with no bubble under continuous flow.
- add_a, add_b and add_cin are combinational. add_cin = cin when beat==0, otherwise carry_q.
- On accept:
  - sum_byte <= add_sum; out_valid <= 1; out_last <= (beat==NBYTES-1).
  - carry_q <= add_cout.
  - sum_word[8*beat +: 8] <= add_sum.
  - beat increments, and wraps to 0 after NBYTES-1.
- On the final-beat accept:
  - cout <= add_cout.
  - ovf <= (a_byte[7]==b_byte[7]) && (add_sum[7]!=a_byte[7]).
  - word_valid pulses high the following cycle.
- If out_valid && out_ready && no new accept: out_valid <= 0.
- sum_word bytes from the previous operation stay visible until they are overwritten. sum_word is only guaranteed coherent while word_valid is high and until the next beat-0 accept.
- abort clears beat, carry_q, out_valid, out_last and word_valid. It leaves sum_word, cout and ovf unchanged. An accept in the same cycle as abort is discarded.
- Reset values are 0 for every register and registered output: beat, carry_q, sum_byte, out_valid, out_last, word_valid, sum_word, cout, ovf.
- After reset, in_ready = 1 because out_valid = 0.

## Timing
- Latency: a byte accepted at edge k appears on sum_byte/out_valid after edge k. word_valid is high for the cycle after the final-beat edge.
- Throughput: one beat per cycle while out_ready is held high. The minimum operation length is NBYTES cycles.
- Backpressure: when out_valid && !out_ready, in_ready = 0. sum_byte, out_last, beat and carry_q then hold stable.
- Upstream must hold a_byte, b_byte and cin stable while in_valid && !in_ready.
- Back-to-back operations: beat wraps to 0 and the next beat-0 accept uses cin, never carry_q.
- word_valid and the first-beat accept of the next operation may coincide. The word registers were written on the previous edge, so they are valid during the pulse.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The next accepted beat is beat 0.

## Structure
- The shared package holds the byte width constant (8) and the NBYTES legal-range constants, plus a typedef for the byte.
- There is one natural sub-module: `out_stage_reg`, the one-entry valid/ready register for sum_byte and out_last. The beat counter, carry register and word assembly live in the top of the block.
- The prefix adder is not instantiated inside; the bench provides a behavioural 8-bit adder on the add_* ports.

## Test plan
- NBYTES=4, A=0x000000FF, B=0x00000001, cin=0, out_ready=1 -> sum_byte sequence 00,01,00,00; out_last only on 4th byte; sum_word=0x00000100; cout=0; ovf=0.
- A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum_byte sequence 00,00,00,00; sum_word=0x00000000; cout=1; ovf=0.
- A=0x7FFFFFFF, B=0x00000000, cin=1 -> sum_word=0x80000000; cout=0; ovf=1.
- Backpressure: out_ready=0 from beat 1 for 3 cycles -> in_ready=0, sum_byte holds 0x01, beat holds; after release the remaining bytes are correct and no beat is lost or duplicated.
- Two back-to-back operations: first 0xFFFFFFFF+1 (cout=1), second 0+0 with cin=0 -> second sum_word=0x00000000, proving no carry leaks across operations.
- rst pulsed after beat 2, then abort exercised mid-operation in a separate run -> all outputs return to reset values (0) or are cleared as specified, with in_ready=1. The next operation 0x00000003+0x00000004 gives 0x00000007.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants and types for the byte-serial wide adder front end.
package wide_add_sequencer_pkg;
   localparam int BYTE_W     = 8;
   localparam int NBYTES_MIN = 2;
   localparam int NBYTES_MAX = 8;

   typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/out_stage_reg.sv
// One-entry valid/ready output register for the sum byte and its last flag.
module out_stage_reg
   import wide_add_sequencer_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clr_i,
   input  logic  load_i,
   input  byte_t data_i,
   input  logic  last_i,
   input  logic  ready_i,
   output logic  valid_o,
   output byte_t data_o,
   output logic  last_o
);

   logic  valid_q, valid_d;
   byte_t data_q, data_d;
   logic  last_q, last_d;

   // Abort drops the pending entry but leaves the data byte as-is.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (clr_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial multi-precision adder front end: drives an external 8-bit adder
// LSB-first and assembles the full-width sum with carry-out and overflow.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                abort,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          a_byte,
   input  logic [7:0]          b_byte,
   input  logic                cin,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          sum_byte,
   output logic                out_last,
   output logic                word_valid,
   output logic [8*NBYTES-1:0] sum_word,
   output logic                cout,
   output logic                ovf
);

   localparam int W      = BYTE_W * NBYTES;
   localparam int BEAT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBYTES - 1);

   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      word_q, word_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              wv_q, wv_d;

   logic accept;
   logic is_last;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !abort;
   assign is_last  = (beat_q == LAST_BEAT);

   assign add_a   = a_byte;
   assign add_b   = b_byte;
   assign add_cin = (beat_q == '0) ? cin : carry_q;

   always_comb begin
      beat_d  = beat_q;
      carry_d = carry_q;
      word_d  = word_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      wv_d    = 1'b0;
      if (abort) begin
         beat_d  = '0;
         carry_d = 1'b0;
      end else if (accept) begin
         carry_d                 = add_cout;
         word_d[beat_q*8 +: 8]   = add_sum;
         if (is_last) begin
            beat_d = '0;
            cout_d = add_cout;
            ovf_d  = (a_byte[7] == b_byte[7]) && (add_sum[7] != a_byte[7]);
            wv_d   = 1'b1;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q  <= '0;
         carry_q <= 1'b0;
         word_q  <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wv_q    <= 1'b0;
      end else begin
         beat_q  <= beat_d;
         carry_q <= carry_d;
         word_q  <= word_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         wv_q    <= wv_d;
      end
   end

   out_stage_reg u_out_stage (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (abort),
      .load_i  (accept),
      .data_i  (add_sum),
      .last_i  (is_last),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (sum_byte),
      .last_o  (out_last)
   );

   assign sum_word   = word_q;
   assign cout       = cout_q;
   assign ovf        = ovf_q;
   assign word_valid = wv_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed self-checking bench for wide_add_sequencer with a behavioural 8-bit adder.
module tb_wide_add_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic         clk = 1'b0;
   logic         rst, abort, in_valid, in_ready, cin;
   logic [7:0]   a_byte, b_byte, add_a, add_b, add_sum, sum_byte;
   logic         add_cin, add_cout, out_valid, out_ready, out_last;
   logic         word_valid, cout, ovf;
   logic [W-1:0] sum_word;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

   wide_add_sequencer #(.NBYTES(NBYTES)) dut (
      .clk(clk), .rst(rst), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_byte(a_byte), .b_byte(b_byte), .cin(cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_byte(sum_byte), .out_last(out_last),
      .word_valid(word_valid), .sum_word(sum_word),
      .cout(cout), .ovf(ovf)
   );

   task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      in_valid = 1'b1; a_byte = a; b_byte = b; cin = c;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_byte = '0; b_byte = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
      vectors++; if (sum_word !== '0) begin miscompares++; $display("FAIL reset sum_word got %h exp 0", sum_word); end
      vectors++; if ({sum_byte, out_last, word_valid, cout, ovf} !== 12'h0) begin
         miscompares++; $display("FAIL reset outputs got sb=%h last=%b wv=%b cout=%b ovf=%b exp all 0", sum_byte, out_last, word_valid, cout, ovf);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_ops();
      logic [W-1:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
      logic [W-1:0] tb [4] = '{32'h00000001, 32'h00000001, 32'h00000000, 32'h80000000};
      logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] ts [4] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000};
      logic         tco[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int v = 0; v < 4; v++) begin
         logic [W-1:0] a, b, s;
         a = ta[v]; b = tb[v]; s = ts[v];
         for (int i = 0; i < NBYTES; i++) begin
            // Non-zero beats carry the inverted cin, which must be ignored.
            drive_beat(a[8*i +: 8], b[8*i +: 8], (i == 0) ? tc[v] : ~tc[v]);
            vectors++; if (sum_byte !== s[8*i +: 8] || out_valid !== 1'b1) begin
               miscompares++; $display("FAIL op%0d byte%0d got %h/v%b exp %h/v1", v, i, sum_byte, out_valid, s[8*i +: 8]);
            end
            vectors++; if (out_last !== (i == NBYTES-1) || word_valid !== (i == NBYTES-1)) begin
               miscompares++; $display("FAIL op%0d beat%0d flags got last=%b wv=%b exp %b", v, i, out_last, word_valid, (i == NBYTES-1));
            end
         end
         vectors++; if (sum_word !== s) begin miscompares++; $display("FAIL op%0d sum_word got %h exp %h", v, sum_word, s); end
         vectors++; if (cout !== tco[v] || ovf !== tov[v]) begin
            miscompares++; $display("FAIL op%0d flags got cout=%b ovf=%b exp cout=%b ovf=%b", v, cout, ovf, tco[v], tov[v]);
         end
         idle();
         vectors++; if (out_valid !== 1'b0 || word_valid !== 1'b0) begin
            miscompares++; $display("FAIL op%0d drain got out_valid=%b wv=%b exp 0/0", v, out_valid, word_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
      drive_beat(8'hFF, 8'h01, 1'b0);
      drive_beat(8'h00, 8'h00, 1'b0);
      @(negedge clk);
      out_ready = 1'b0; a_byte = 8'h00; b_byte = 8'h00; in_valid = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp in_ready got %b exp 0", in_ready); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         vectors++; if (sum_byte !== 8'h01 || out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp hold%0d got sb=%h v=%b last=%b rdy=%b exp 01/1/0/0", k, sum_byte, out_valid, out_last, in_ready);
         end
      end
      @(negedge clk); out_ready = 1'b1;
      for (int i = 2; i < NBYTES; i++) begin
         if (i > 2) @(negedge clk);
         @(posedge clk); #1;
         vectors++; if (sum_byte !== exp_b[i] || out_last !== (i == NBYTES-1)) begin
            miscompares++; $display("FAIL bp byte%0d got %h last=%b exp %h last=%b", i, sum_byte, out_last, exp_b[i], (i == NBYTES-1));
         end
      end
      vectors++; if (word_valid !== 1'b1 || sum_word !== 32'h00000100 || cout !== 1'b0) begin
         miscompares++; $display("FAIL bp word got wv=%b %h cout=%b exp 1 00000100 0", word_valid, sum_word, cout);
      end
      idle();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp extra beat out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NBYTES; i++) drive_beat(8'hFF, (i == 0) ? 8'h01 : 8'h00, 1'b0);
      vectors++; if (word_valid !== 1'b1 || cout !== 1'b1 || sum_word !== '0) begin
         miscompares++; $display("FAIL b2b first got wv=%b cout=%b %h exp 1 1 00000000", word_valid, cout, sum_word);
      end
      for (int i = 0; i < NBYTES; i++) begin
         drive_beat(8'h00, 8'h00, 1'b0);
         vectors++; if (sum_byte !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b second byte%0d got %h rdy=%b exp 00 1", i, sum_byte, in_ready);
         end
      end
      vectors++; if (word_valid !== 1'b1 || sum_word !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         miscompares++; $display("FAIL b2b second got wv=%b %h cout=%b ovf=%b exp 1 0 0 0", word_valid, sum_word, cout, ovf);
      end
      idle();
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 3; i++) drive_beat(8'h81, 8'h82, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_word !== '0 || {sum_byte, cout, ovf, out_last} !== 11'h0) begin
         miscompares++; $display("FAIL rst_mid got v=%b rdy=%b %h sb=%h cout=%b ovf=%b exp all cleared", out_valid, in_ready, sum_word, sum_byte, cout, ovf);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
         drive_beat((i == 0) ? 8'h03 : 8'h00, (i == 0) ? 8'h04 : 8'h00, 1'b0);
         vectors++; if (sum_byte !== ((i == 0) ? 8'h07 : 8'h00) || out_last !== (i == NBYTES-1)) begin
            miscompares++; $display("FAIL rst_mid byte%0d got %h last=%b", i, sum_byte, out_last);
         end
      end
      vectors++; if (sum_word !== 32'h00000007) begin miscompares++; $display("FAIL rst_mid sum_word got %h exp 00000007", sum_word); end
      idle();
   endtask

   task automatic test_abort();
      for (int i = 0; i < NBYTES; i++) drive_beat((i == NBYTES-1) ? 8'h80 : 8'h00, (i == NBYTES-1) ? 8'h80 : 8'h00, 1'b0);
      drive_beat(8'h11, 8'h22, 1'b0);
      drive_beat(8'h11, 8'h22, 1'b0);
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1; a_byte = 8'h11; b_byte = 8'h22;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || word_valid !== 1'b0) begin
         miscompares++; $display("FAIL abort clear got v=%b last=%b rdy=%b wv=%b exp 0 0 1 0", out_valid, out_last, in_ready, word_valid);
      end
      vectors++; if (sum_word !== 32'h00003333 || cout !== 1'b1 || ovf !== 1'b1) begin
         miscompares++; $display("FAIL abort keep got %h cout=%b ovf=%b exp 00003333 1 1", sum_word, cout, ovf);
      end
      @(negedge clk); abort = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
         drive_beat((i == 0) ? 8'h03 : 8'h00, (i == 0) ? 8'h04 : 8'h00, 1'b0);
         vectors++; if (sum_byte !== ((i == 0) ? 8'h07 : 8'h00) || out_last !== (i == NBYTES-1)) begin
            miscompares++; $display("FAIL abort next byte%0d got %h last=%b", i, sum_byte, out_last);
         end
      end
      vectors++; if (sum_word !== 32'h00000007 || cout !== 1'b0 || ovf !== 1'b0) begin
         miscompares++; $display("FAIL abort next got %h cout=%b ovf=%b exp 00000007 0 0", sum_word, cout, ovf);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_back_to_back();
      test_rst_mid();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
